// File: rtl/preimage_enumerator.sv
// preimage_enumerator
//   Inverts the fixed 3-to-2 code law F (000->00, 001->01, 01x->10, 10x->11,
//   11x->00). For each accepted 2-bit code it emits every 3-bit word x with
//   F(x) equal to that code, in ascending order. One candidate index is
//   evaluated per cycle. Stall cycles hold the current word.
//
// Ports
//   clock, reset           rising-edge clock, synchronous active-high reset
//   code_valid/code_ready  input code handshake, code = {z1,z0}
//   x_valid/x_ready        preimage word handshake, word = {x2,x1,x0}
//   x_last                 the presented word is the final preimage of the code
//   pre_count              size of the current code's preimage set (00 when idle)
//
// Every output is a function of registers only.
module preimage_enumerator (
    input  logic       clock,
    input  logic       reset,
    input  logic       code_valid,
    output logic       code_ready,
    input  logic       z1,
    input  logic       z0,
    output logic       x_valid,
    input  logic       x_ready,
    output logic       x2,
    output logic       x1,
    output logic       x0,
    output logic       x_last,
    output logic [1:0] pre_count
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t     state;
    logic [1:0] code_q;
    logic [2:0] idx;
    logic       init_done;   // holds code_ready low through the reset cycle
    logic       match;
    logic       more;

    function automatic logic [1:0] f_code(input logic [2:0] x);
        logic [1:0] r;
        case (x[2:1])
            2'b00:   r = {1'b0, x[0]};
            2'b01:   r = 2'b10;
            2'b10:   r = 2'b11;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    // match: current index is a preimage. more: a later index also is.
    always_comb begin
        match = (f_code(idx) == code_q);
        more  = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if ((3'(j) > idx) && (f_code(3'(j)) == code_q))
                more = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            code_q    <= 2'b00;
            idx       <= 3'd0;
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
            case (state)
                IDLE: begin
                    if (code_valid && code_ready) begin
                        code_q <= {z1, z0};
                        idx    <= 3'd0;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (!match) begin
                        idx <= idx + 3'd1;
                    end else if (x_ready) begin
                        // No wrap possible: the last preimage of any code
                        // ends the scan before idx would pass 7.
                        if (!more) state <= IDLE;
                        else       idx   <= idx + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        code_ready   = (state == IDLE) && init_done;
        x_valid      = (state == SCAN) && match;
        {x2, x1, x0} = x_valid ? idx : 3'b000;
        x_last       = x_valid && !more;
        pre_count    = 2'b00;
        if (state == SCAN) begin
            case (code_q)
                2'b00:   pre_count = 2'd3;
                2'b01:   pre_count = 2'd1;
                default: pre_count = 2'd2;
            endcase
        end
    end

endmodule
